// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared state encoding and width helpers for the SRAM port arbiter
package sram_arbiter_pkg;
  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;
  function automatic int addr_width(input int entries);
    return entries > 1 ? $clog2(entries) : 1;
  endfunction
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: pick the first masked request scanning from ptr, wrapping modulo n
module rr_priority_picker #(
  parameter int n = 4,
  parameter int pw = 2
) (
  input  logic [n-1:0]  request_i,
  input  logic [n-1:0]  mask_i,
  input  logic [pw-1:0] ptr_i,
  output logic [n-1:0]  grant_o,
  output logic [pw-1:0] index_o,
  output logic          valid_o
);
  logic [n-1:0] req;
  logic [pw-1:0] idx;
  assign req = request_i & mask_i;
  assign grant_o = valid_o ? n'(1) << index_o : '0;
  // scan from the far end back towards ptr so the closest hit is the last one kept
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    idx = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = pw'((int'(ptr_i) + k) % n);
      if (req[idx]) begin
        index_o = idx;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM port with bounded burst locking
module sram_port_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int nr_of_requesters = 4,
  parameter int bitwidth = 32,
  parameter int nr_of_entries = 512,
  parameter int max_burst = 16,
  localparam int AW = addr_width(nr_of_entries),
  localparam int PW = ptr_width(nr_of_requesters),
  localparam int BW = $clog2(max_burst) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [nr_of_requesters-1:0]      request_vector_i,
  input  logic [nr_of_requesters-1:0]      write_enable_vector_i,
  input  logic [nr_of_requesters-1:0]      lock_vector_i,
  input  logic [nr_of_requesters*AW-1:0]   address_vector_i,
  input  logic [nr_of_requesters*bitwidth-1:0] data_in_vector_i,
  output logic [nr_of_requesters-1:0]      grant_vector_o,
  output logic [nr_of_requesters-1:0]      read_valid_vector_o,
  output logic [bitwidth-1:0]              read_data_o,
  output logic                             sram_write_enable_o,
  output logic [AW-1:0]                    sram_address_o,
  output logic [bitwidth-1:0]              sram_data_in_o,
  input  logic [bitwidth-1:0]              sram_data_out_i
);
  localparam int N = nr_of_requesters;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, gidx;
  logic [BW-1:0] bc_q, bc_d;
  logic [N-1:0] rv_q, own_mask, mask;
  logic any, others;
  assign own_mask = N'(1) << owner_q;
  assign mask = state_q == LOCKED ? own_mask : '1;
  assign others = |(request_vector_i & ~own_mask);
  rr_priority_picker #(.n(N), .pw(PW)) u_picker (
    .request_i(request_vector_i),
    .mask_i(mask),
    .ptr_i(ptr_q),
    .grant_o(grant_vector_o),
    .index_o(gidx),
    .valid_o(any)
  );
  assign sram_address_o = address_vector_i[int'(gidx)*AW +: AW];
  assign sram_data_in_o = data_in_vector_i[int'(gidx)*bitwidth +: bitwidth];
  assign sram_write_enable_o = any & write_enable_vector_i[gidx];
  assign read_valid_vector_o = rv_q;
  assign read_data_o = sram_data_out_i;
  // lock FSM: ptr only moves on ARB grants since a lock always releases with ptr at owner+1;
  // idle starved cycles use up one more burst slot than granted ones so waiters get in sooner
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    bc_d = bc_q;
    if (state_q == ARB) begin
      if (any) begin
        ptr_d = gidx == PW'(N - 1) ? '0 : gidx + 1'b1;
        if (lock_vector_i[gidx] && max_burst > 1) begin
          state_d = LOCKED;
          owner_d = gidx;
          bc_d = BW'(1);
        end
      end
    end else if (any) begin
      bc_d = bc_q + 1'b1;
      if (!lock_vector_i[owner_q] || bc_q >= BW'(max_burst - 1)) state_d = ARB;
    end else if (!lock_vector_i[owner_q]) begin
      state_d = ARB;
    end else if (others) begin
      bc_d = bc_q + 1'b1;
      if (bc_q + 1'b1 >= BW'(max_burst - 1)) state_d = ARB;
    end
  end
  // state registers; a granted read flags its requester one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q <= '0;
      owner_q <= '0;
      bc_q <= '0;
      rv_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      bc_q <= bc_d;
      rv_q <= grant_vector_o & ~write_enable_vector_i;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vector table plus random traffic against a behavioural model
module tb_sram_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int AW = 9;
  localparam int MB = 4;
  localparam logic [N*AW-1:0] A0 = {9'd3, 9'd2, 9'd1, 9'd0};
  typedef struct {
    bit rst;
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic [N-1:0] lk;
    logic [N*AW-1:0] addr;
    logic [N*W-1:0] din;
    int exp_g;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req, we, lk, grant, rv;
  logic [N*AW-1:0] addr;
  logic [N*W-1:0] din;
  logic [W-1:0] rdata, sram_din, sram_dout;
  logic [AW-1:0] sram_addr;
  logic sram_we;
  logic [W-1:0] mem [512];
  logic [W-1:0] shadow [512];
  bit m_locked;
  int m_ptr, m_owner, m_used, cur;
  logic [N-1:0] m_rv;
  logic [W-1:0] m_rd;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  sram_port_arbiter #(.nr_of_requesters(N), .bitwidth(W), .nr_of_entries(512), .max_burst(MB)) dut (
    .clk(clk),
    .rst(rst),
    .request_vector_i(req),
    .write_enable_vector_i(we),
    .lock_vector_i(lk),
    .address_vector_i(addr),
    .data_in_vector_i(din),
    .grant_vector_o(grant),
    .read_valid_vector_o(rv),
    .read_data_o(rdata),
    .sram_write_enable_o(sram_we),
    .sram_address_o(sram_addr),
    .sram_data_in_o(sram_din),
    .sram_data_out_i(sram_dout)
  );
  // write-first synchronous SRAM port with one cycle read latency
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    sram_dout <= sram_we ? sram_din : mem[sram_addr];
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask
  function automatic bit has(input logic [N-1:0] v, input int j);
    logic [N-1:0] s;
    s = v >> j;
    return s[0];
  endfunction
  function automatic vec_t mk(input bit r, input logic [N-1:0] rq, input logic [N-1:0] w,
                              input logic [N-1:0] l, input logic [N*AW-1:0] a,
                              input logic [N*W-1:0] d, input int g);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.lk = l; v.addr = a; v.din = d; v.exp_g = g;
    return v;
  endfunction
  // who should win this cycle: the lock owner alone, or the first requester from ptr onwards
  function automatic int pick(input logic [N-1:0] rq);
    if (m_locked) return has(rq, m_owner) ? m_owner : -1;
    for (int k = 0; k < N; k++) if (has(rq, (m_ptr + k) % N)) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic apply(input vec_t v);
    int g, ga;
    logic [AW-1:0] a;
    rst = v.rst; req = v.req; we = v.we; lk = v.lk; addr = v.addr; din = v.din;
    @(negedge clk);
    g = pick(v.req);
    ga = g < 0 ? 0 : g;
    a = v.addr[ga*AW +: AW];
    if (v.exp_g != -2) chk("table_grant", grant, v.exp_g < 0 ? 0 : 1 << v.exp_g);
    chk("grant", grant, g < 0 ? 0 : 1 << g);
    chk("sram_we", sram_we, g >= 0 && has(v.we, g));
    chk("sram_addr", sram_addr, a);
    chk("sram_din", sram_din, v.din[ga*W +: W]);
    chk("read_valid", rv, m_rv);
    if (m_rv != 0) chk("read_data", rdata, m_rd);
    m_rv = '0;
    if (g >= 0) begin
      if (has(v.we, g)) shadow[a] = v.din[g*W +: W];
      else begin
        m_rv = N'(1) << g;
        m_rd = shadow[a];
      end
    end
    if (v.rst) begin
      m_locked = 0; m_ptr = 0; m_owner = 0; m_used = 0; m_rv = '0;
    end else if (!m_locked) begin
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (has(v.lk, g)) begin
          m_locked = 1; m_owner = g; m_used = 1;
        end
      end
    end else if (g >= 0) begin
      m_used++;
      if (!has(v.lk, m_owner) || m_used >= MB) m_locked = 0;
    end else if (!has(v.lk, m_owner)) begin
      m_locked = 0;
    end else if ((v.req & ~(N'(1) << m_owner)) != 0) begin
      m_used++;
      if (m_used >= MB - 1) m_locked = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hA500_0000 + i;
      shadow[i] = 32'hA500_0000 + i;
    end
    req = '0; we = '0; lk = '0; addr = '0; din = '0;
    m_locked = 0; m_ptr = 0; m_owner = 0; m_used = 0; m_rv = '0; m_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, A0, '0, -1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, A0, '0, i % N));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, {9'd0, 9'd5, 9'd0, 9'd0}, {32'd0, 32'hDEADBEEF, 64'd0}, 2));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, {27'd0, 9'd5}, '0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, A0, '0, -1));
    foreach (vecs[i]) if (0) vecs[i].exp_g = -2;
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 3));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, A0, '0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, A0, '0, -1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, A0, '0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0001, A0, '0, -1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0001, A0, '0, -1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, A0, '0, 2));
    vecs.push_back(mk(0, 4'b1000, 4'b0000, 4'b0000, A0, '0, 3));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, A0, '0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 4'b0000, A0, '0, 3));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 4'b0000, A0, '0, 1));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 4'b0000, A0, '0, 1));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, A0, '0, 2));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0100, A0, '0, 2));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, A0, '0, 0));
    for (int i = 0; i < 600; i++) begin
      logic [N*AW-1:0] a;
      for (int j = 0; j < N; j++) a[j*AW +: AW] = AW'($urandom_range(0, 15));
      vecs.push_back(mk($urandom_range(0, 49) == 0, N'($urandom), N'($urandom),
                        $urandom_range(0, 3) == 0 ? '0 : N'($urandom), a,
                        {$urandom, $urandom, $urandom, $urandom}, -2));
    end
    foreach (vecs[i]) begin
      cur = i;
      apply(vecs[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
